// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU operand/op-select path among NREQ clients.
// The winner's operands are registered at grant, held while the ALU works, and the result is returned tagged.
module alu_share_arbiter #(
   parameter int NREQ     = 4,
   parameter int WIDTH    = 16,
   parameter int OPW      = 3,
   parameter int ALU_LAT  = 1,
   localparam int IDW     = $clog2(NREQ),
   localparam int CW      = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*OPW-1:0]   req_op,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       gnt,
   output logic [OPW-1:0]        alu_sel,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   input  logic [WIDTH-1:0]      alu_result,
   output logic                  busy,
   output logic                  rsp_valid,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_data
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]   win_q, win_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [OPW-1:0]   alu_sel_q, alu_sel_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

   logic [OPW-1:0]   op_arr [NREQ];
   logic [WIDTH-1:0] a_arr  [NREQ];
   logic [WIDTH-1:0] b_arr  [NREQ];

   logic             win_found;
   logic [IDW-1:0]   win_idx;
   logic [IDW-1:0]   scan_idx;
   logic [IDW-1:0]   rr_after_win;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
         assign op_arr[gi] = req_op[gi*OPW +: OPW];
         assign a_arr[gi]  = req_a[gi*WIDTH +: WIDTH];
         assign b_arr[gi]  = req_b[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Scan rr_ptr, rr_ptr+1, ... (mod NREQ); the first asserted request wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (int'(rr_ptr_q) + k >= NREQ) begin
            scan_idx = IDW'(int'(rr_ptr_q) + k - NREQ);
         end else begin
            scan_idx = IDW'(int'(rr_ptr_q) + k);
         end
         if (!win_found && req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   assign rr_after_win = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         win_q      <= '0;
         cnt_q      <= '0;
         gnt_q      <= '0;
         alu_sel_q  <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         rsp_id_q   <= '0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         win_q      <= win_d;
         cnt_q      <= cnt_d;
         gnt_q      <= gnt_d;
         alu_sel_q  <= alu_sel_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         rsp_id_q   <= rsp_id_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      win_d      = win_q;
      cnt_d      = cnt_q;
      gnt_d      = '0;
      alu_sel_d  = alu_sel_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      rsp_id_d   = rsp_id_q;
      rsp_data_d = rsp_data_q;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               state_d   = S_BUSY;
               win_d     = win_idx;
               rr_ptr_d  = rr_after_win;
               cnt_d     = CW'(ALU_LAT - 1);
               gnt_d     = NREQ'(1) << win_idx;
               alu_sel_d = op_arr[win_idx];
               alu_a_d   = a_arr[win_idx];
               alu_b_d   = b_arr[win_idx];
            end
         end
         S_BUSY: begin
            // Requests arriving here are ignored; the op in flight always completes.
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               state_d    = S_RESP;
               rsp_data_d = alu_result;
               rsp_id_d   = win_q;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      busy      = (state_q != S_IDLE);
      rsp_valid = (state_q == S_RESP);
      gnt       = gnt_q;
      alu_sel   = alu_sel_q;
      alu_a     = alu_a_q;
      alu_b     = alu_b_q;
      rsp_id    = rsp_id_q;
      rsp_data  = rsp_data_q;
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: two instances (ALU_LAT=1 and ALU_LAT=3) on shared stimulus,
// checked every cycle against a timing-arithmetic reference model plus directed vectors.
module tb_alu_share_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 16;
   localparam int OPW  = 3;

   logic                clk;
   logic                rst_n;
   logic [NREQ-1:0]     req;
   logic [NREQ*OPW-1:0] req_op;
   logic [NREQ*W-1:0]   req_a;
   logic [NREQ*W-1:0]   req_b;

   logic [NREQ-1:0] o_gnt  [2];
   logic [OPW-1:0]  o_sel  [2];
   logic [W-1:0]    o_a    [2];
   logic [W-1:0]    o_b    [2];
   logic            o_busy [2];
   logic            o_rv   [2];
   logic [1:0]      o_id   [2];
   logic [W-1:0]    o_data [2];
   logic [W-1:0]    alu_res [2];

   logic            ovr_on;
   logic [W-1:0]    ovr_val;

   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [W-1:0] alu_f(input logic [OPW-1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return {a[7:0], b[7:0]};
         3'd6:    return ~a;
         default: return b;
      endcase
   endfunction

   assign alu_res[0] = alu_f(o_sel[0], o_a[0], o_b[0]);
   assign alu_res[1] = ovr_on ? ovr_val : alu_f(o_sel[1], o_a[1], o_b[1]);

   alu_share_arbiter #(.NREQ(NREQ), .WIDTH(W), .OPW(OPW), .ALU_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .gnt(o_gnt[0]), .alu_sel(o_sel[0]), .alu_a(o_a[0]), .alu_b(o_b[0]),
      .alu_result(alu_res[0]), .busy(o_busy[0]), .rsp_valid(o_rv[0]),
      .rsp_id(o_id[0]), .rsp_data(o_data[0])
   );

   alu_share_arbiter #(.NREQ(NREQ), .WIDTH(W), .OPW(OPW), .ALU_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .gnt(o_gnt[1]), .alu_sel(o_sel[1]), .alu_a(o_a[1]), .alu_b(o_b[1]),
      .alu_result(alu_res[1]), .busy(o_busy[1]), .rsp_valid(o_rv[1]),
      .rsp_id(o_id[1]), .rsp_data(o_data[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a transaction issues when the arbiter has been free for LAT+2 edges since
   // the last issue; response appears LAT edges after issue; busy spans issue..issue+LAT.
   int              ecnt = 0;
   int              m_rr   [2];
   int              m_last [2];
   int              m_win  [2];
   logic [NREQ-1:0] m_gnt  [2];
   logic [OPW-1:0]  m_sel  [2];
   logic [W-1:0]    m_a    [2];
   logic [W-1:0]    m_b    [2];
   logic [1:0]      m_id   [2];
   logic [W-1:0]    m_data [2];
   int              m_lat, m_c;
   bit              m_found;
   bit              e_busy, e_rv;

   always @(posedge clk) begin
      ecnt++;
      for (int k = 0; k < 2; k++) begin
         m_lat = (k == 0) ? 1 : 3;
         if (!rst_n) begin
            m_rr[k]   = 0;
            m_last[k] = -1000;
            m_win[k]  = 0;
            m_gnt[k]  = '0;
            m_sel[k]  = '0;
            m_a[k]    = '0;
            m_b[k]    = '0;
            m_id[k]   = '0;
            m_data[k] = '0;
         end else begin
            m_gnt[k] = '0;
            if (ecnt == m_last[k] + m_lat) begin
               m_id[k]   = 2'(m_win[k]);
               m_data[k] = (k == 1 && ovr_on) ? ovr_val : alu_f(m_sel[k], m_a[k], m_b[k]);
               $display("[TB] dut%0d edge %0d rsp id=%0d data=%h", k, ecnt, m_id[k], m_data[k]);
            end
            if (ecnt >= m_last[k] + m_lat + 2 && req != '0) begin
               m_found = 1'b0;
               for (int j = 0; j < NREQ; j++) begin
                  m_c = (m_rr[k] + j) % NREQ;
                  if (!m_found && req[m_c]) begin
                     m_found   = 1'b1;
                     m_win[k]  = m_c;
                     m_gnt[k]  = 4'b0001 << m_c;
                     m_sel[k]  = req_op[m_c*OPW +: OPW];
                     m_a[k]    = req_a[m_c*W +: W];
                     m_b[k]    = req_b[m_c*W +: W];
                     m_rr[k]   = (m_c + 1) % NREQ;
                     m_last[k] = ecnt;
                  end
               end
            end
         end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         m_lat  = (k == 0) ? 1 : 3;
         e_busy = (rst_n && ecnt <= m_last[k] + m_lat);
         e_rv   = (rst_n && ecnt == m_last[k] + m_lat);
         chk($sformatf("m%0d_gnt", k),  64'(o_gnt[k]),  64'(m_gnt[k]));
         chk($sformatf("m%0d_busy", k), 64'(o_busy[k]), 64'(e_busy));
         chk($sformatf("m%0d_rv", k),   64'(o_rv[k]),   64'(e_rv));
         chk($sformatf("m%0d_sel", k),  64'(o_sel[k]),  64'(m_sel[k]));
         chk($sformatf("m%0d_a", k),    64'(o_a[k]),    64'(m_a[k]));
         chk($sformatf("m%0d_b", k),    64'(o_b[k]),    64'(m_b[k]));
         chk($sformatf("m%0d_id", k),   64'(o_id[k]),   64'(m_id[k]));
         chk($sformatf("m%0d_data", k), 64'(o_data[k]), 64'(m_data[k]));
      end
   end

   typedef struct {
      logic [NREQ-1:0] rq;
      int              win;
      logic [OPW-1:0]  op;
      logic [W-1:0]    a;
      logic [W-1:0]    b;
   } vec_t;

   vec_t tv [8];
   bit   seen;

   task automatic edge_chk();
      @(posedge clk);
      #2;
   endtask

   initial begin
      // Expected winners follow the pointer from reset: 2 (->3), 0,1 (wrap/skip), 3,3,3 (sole), 1,2.
      tv[0] = '{4'b0100, 2, 3'd5, 16'h1234, 16'h0F0F};
      tv[1] = '{4'b0011, 0, 3'd0, 16'hFFFF, 16'h0001};
      tv[2] = '{4'b0011, 1, 3'd1, 16'h0000, 16'h0001};
      tv[3] = '{4'b1001, 3, 3'd2, 16'hA5A5, 16'h0FF0};
      tv[4] = '{4'b1000, 3, 3'd3, 16'h8000, 16'h0001};
      tv[5] = '{4'b1000, 3, 3'd4, 16'hFFFF, 16'h00FF};
      tv[6] = '{4'b0110, 1, 3'd6, 16'h1357, 16'h0000};
      tv[7] = '{4'b0110, 2, 3'd7, 16'h0000, 16'hBEEF};

      rst_n = 1'b0; req = 4'b1111; ovr_on = 1'b0; ovr_val = '0;
      req_op = 12'($urandom); req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
      edge_chk();
      edge_chk();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst%0d_gnt", k),  64'(o_gnt[k]),  64'(0));
         chk($sformatf("rst%0d_busy", k), 64'(o_busy[k]), 64'(0));
         chk($sformatf("rst%0d_rv", k),   64'(o_rv[k]),   64'(0));
         chk($sformatf("rst%0d_alu", k),  64'({o_sel[k], o_a[k], o_b[k]}), 64'(0));
         chk($sformatf("rst%0d_rsp", k),  64'({o_id[k], o_data[k]}), 64'(0));
      end

      // Directed vector table on the ALU_LAT=1 instance.
      @(negedge clk);
      rst_n = 1'b1; req = '0;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            req_op[i*OPW +: OPW] = (i == tv[t].win) ? tv[t].op : 3'($urandom);
            req_a[i*W +: W]      = (i == tv[t].win) ? tv[t].a  : 16'($urandom);
            req_b[i*W +: W]      = (i == tv[t].win) ? tv[t].b  : 16'($urandom);
         end
         req = tv[t].rq;
         edge_chk();
         chk($sformatf("tv%0d_gnt", t),  64'(o_gnt[0]), 64'(4'b0001 << tv[t].win));
         chk($sformatf("tv%0d_sel", t),  64'(o_sel[0]), 64'(tv[t].op));
         chk($sformatf("tv%0d_a", t),    64'(o_a[0]),   64'(tv[t].a));
         chk($sformatf("tv%0d_b", t),    64'(o_b[0]),   64'(tv[t].b));
         chk($sformatf("tv%0d_busy", t), 64'(o_busy[0]), 64'(1));
         @(negedge clk);
         req = '0;
         edge_chk();
         chk($sformatf("tv%0d_gnt_clr", t), 64'(o_gnt[0]), 64'(0));
         chk($sformatf("tv%0d_rv", t),      64'(o_rv[0]),  64'(1));
         chk($sformatf("tv%0d_id", t),      64'(o_id[0]),  64'(tv[t].win));
         chk($sformatf("tv%0d_data", t),    64'(o_data[0]), 64'(alu_f(tv[t].op, tv[t].a, tv[t].b)));
         edge_chk();
         chk($sformatf("tv%0d_rv_clr", t), 64'(o_rv[0]),   64'(0));
         chk($sformatf("tv%0d_idle", t),   64'(o_busy[0]), 64'(0));
         $display("[TB] vector %0d: req=%b winner=%0d data=%h", t, tv[t].rq, o_id[0], o_data[0]);
      end

      // Fairness from reset with every client requesting continuously.
      @(negedge clk);
      rst_n = 1'b0; req = 4'b1111;
      edge_chk();
      edge_chk();
      @(negedge clk);
      rst_n = 1'b1;
      for (int g = 0; g < 5; g++) begin
         seen = 1'b0;
         for (int c = 0; c < 8 && !seen; c++) begin
            edge_chk();
            seen = (o_gnt[0] != '0);
         end
         chk($sformatf("fair%0d_gnt_seen", g), 64'(seen), 64'(1));
         chk($sformatf("fair%0d_gnt", g), 64'(o_gnt[0]), 64'(4'b0001 << (g % 4)));
         seen = 1'b0;
         for (int c = 0; c < 8 && !seen; c++) begin
            edge_chk();
            seen = o_rv[0];
         end
         chk($sformatf("fair%0d_rv_seen", g), 64'(seen), 64'(1));
         chk($sformatf("fair%0d_id", g), 64'(o_id[0]), 64'(g % 4));
      end
      @(negedge clk);
      req = '0;
      repeat (6) @(negedge clk);

      // Reset in the middle of an operation: response is dropped and the pointer restarts at 0.
      req = 4'b0100;
      edge_chk();
      chk("midrst_gnt1", 64'(o_gnt[0]), 64'(4'b0100));
      chk("midrst_gnt3", 64'(o_gnt[1]), 64'(4'b0100));
      @(negedge clk);
      rst_n = 1'b0; req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         edge_chk();
         chk($sformatf("midrst_norv1_%0d", c), 64'(o_rv[0]), 64'(0));
         chk($sformatf("midrst_norv3_%0d", c), 64'(o_rv[1]), 64'(0));
      end
      @(negedge clk);
      req = 4'b1010;
      edge_chk();
      chk("midrst_regnt1", 64'(o_gnt[0]), 64'(4'b0010));
      chk("midrst_regnt3", 64'(o_gnt[1]), 64'(4'b0010));
      @(negedge clk);
      req = '0;
      repeat (6) @(negedge clk);

      // ALU_LAT=3: operands stable three cycles, result sampled on the third BUSY edge.
      req_op[2:0] = 3'd2; req_a[15:0] = 16'h5A5A; req_b[15:0] = 16'h3C3C;
      req = 4'b0001; ovr_on = 1'b1; ovr_val = 16'hC000;
      edge_chk();
      chk("lat3_gnt", 64'(o_gnt[1]), 64'(4'b0001));
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         req = '0;
         ovr_val = 16'hC000 + 16'(c);
         chk($sformatf("lat3_a_%0d", c), 64'(o_a[1]), 64'(16'h5A5A));
         chk($sformatf("lat3_b_%0d", c), 64'(o_b[1]), 64'(16'h3C3C));
         edge_chk();
         chk($sformatf("lat3_rv_%0d", c), 64'(o_rv[1]), 64'(c == 3));
      end
      chk("lat3_data", 64'(o_data[1]), 64'(16'hC003));
      chk("lat3_id", 64'(o_id[1]), 64'(0));
      @(negedge clk);
      ovr_val = 16'hC004;
      edge_chk();
      chk("lat3_rv_clr", 64'(o_rv[1]), 64'(0));
      chk("lat3_idle", 64'(o_busy[1]), 64'(0));
      chk("lat3_data_hold", 64'(o_data[1]), 64'(16'hC003));
      @(negedge clk);
      ovr_on = 1'b0;

      // Randomized traffic including occasional resets; the model checks every edge.
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         rst_n  = ($urandom_range(0, 99) != 0);
         req    = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
         req_op = 12'($urandom);
         req_a  = {$urandom, $urandom};
         req_b  = {$urandom, $urandom};
      end
      @(negedge clk);
      req = '0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
